// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter: round-robin arbiter and sequencer that shares one
// strobe/ack FP32 multiplier between NUM_REQ requesters. One operation is
// in flight at a time: accept, send A, send B, wait for Z, return the
// product to the granted requester over its valid/ready response channel.
// Products pass through untouched; no arithmetic happens here.
module fp_mul_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [31:0]             mul_a,
  output logic [31:0]             mul_b,
  output logic                    mul_a_stb,
  input  logic                    mul_a_ack,
  output logic                    mul_b_stb,
  input  logic                    mul_b_ack,
  input  logic [31:0]             mul_z,
  input  logic                    mul_z_stb,
  output logic                    mul_z_ack,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND_A = 3'd1;
  localparam logic [2:0] S_SEND_B = 3'd2;
  localparam logic [2:0] S_WAIT_Z = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Requester 0 wins first after reset because the search starts at last+1.
  localparam logic [ID_W-1:0] LAST_GRANT_RST = ID_W'(NUM_REQ - 1);

  logic [2:0]      state_q, state_d;
  logic [31:0]     mul_a_q, mul_a_d;
  logic [31:0]     mul_b_q, mul_b_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;

  logic [ID_W-1:0] sel_id;
  logic            sel_found;
  logic [31:0]     sel_a, sel_b;
  logic            rsp_fire;

  // Round-robin pick: first valid requester at or after last_grant+1, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any condition, so no path
    // leaves it unassigned and no latch is inferred.
    sel_id    = '0;
    sel_found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!sel_found && req_valid[i] &&
            (i == (int'(last_grant_q) + off) % NUM_REQ)) begin
          sel_found = 1'b1;
          sel_id    = ID_W'(i);
        end
      end
    end
  end

  // Operand mux and per-requester handshake outputs.
  always_comb begin
    sel_a     = '0;
    sel_b     = '0;
    req_ready = '0;
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_id == ID_W'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
      req_ready[i] = (state_q == S_IDLE) && sel_found && (sel_id == ID_W'(i));
      rsp_valid[i] = (state_q == S_RESP) && (grant_id_q == ID_W'(i));
    end
  end

  // Only the granted requester's rsp_ready matters; rsp_valid is one-hot.
  assign rsp_fire  = |(rsp_valid & rsp_ready);

  assign mul_a_stb = (state_q == S_SEND_A);
  assign mul_b_stb = (state_q == S_SEND_B);
  // Acked in the same cycle the strobe is seen; WAIT_Z is left at once, so
  // the ack can never last more than one cycle.
  assign mul_z_ack = (state_q == S_WAIT_Z) && mul_z_stb;
  assign busy      = (state_q != S_IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_data  = rsp_data_q;
  assign grant_id  = grant_id_q;

  // Sequencer next-state: accept, drive A then B, collect Z, hand back result.
  always_comb begin
    state_d      = state_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    rsp_data_d   = rsp_data_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          mul_a_d    = sel_a;
          mul_b_d    = sel_b;
          grant_id_d = sel_id;
          state_d    = S_SEND_A;
        end
      end
      S_SEND_A: if (mul_a_ack) state_d = S_SEND_B;
      S_SEND_B: if (mul_b_ack) state_d = S_WAIT_Z;
      S_WAIT_Z: begin
        if (mul_z_stb) begin
          rsp_data_d = mul_z;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_fire) begin
          last_grant_d = grant_id_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_data_q   <= '0;
      grant_id_q   <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      rsp_data_q   <= rsp_data_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// tb_fp_mul_arbiter: directed vectors plus hand-written multi-cycle
// sequences for fp_mul_arbiter, against a small strobe/ack multiplier model
// with programmable ack and compute delays.
module tb_fp_mul_arbiter;

  localparam int N  = 2;
  localparam int IW = 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [31:0]     rsp_data, mul_a, mul_b, mul_z;
  logic            mul_a_stb, mul_a_ack, mul_b_stb, mul_b_ack;
  logic            mul_z_stb, mul_z_ack, busy;
  logic [IW-1:0]   grant_id;

  logic [31:0] a_arr [N];
  logic [31:0] b_arr [N];
  assign req_a = {a_arr[1], a_arr[0]};
  assign req_b = {b_arr[1], b_arr[0]};

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_a_stb(mul_a_stb), .mul_a_ack(mul_a_ack),
    .mul_b_stb(mul_b_stb), .mul_b_ack(mul_b_ack),
    .mul_z(mul_z), .mul_z_stb(mul_z_stb), .mul_z_ack(mul_z_ack),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- multiplier model ----------------
  int          ack_dly = 0;
  int          z_dly   = 0;
  int          a_cnt, b_cnt, z_cnt;
  logic        z_busy;
  logic [31:0] m_a;

  assign mul_a_ack = mul_a_stb && (a_cnt >= ack_dly);
  assign mul_b_ack = mul_b_stb && (b_cnt >= ack_dly);

  // Known products for the operand pairs used below; anything else is a
  // recognisable scramble so a wrong operand shows up in rsp_data.
  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40000000_40400000: return 32'h40C00000; // 2.0 * 3.0
      64'h3FC00000_C0000000: return 32'hC0400000; // 1.5 * -2.0
      64'h7F800000_00000001: return 32'h7F800000; // inf * denormal
      64'h7FC00001_40400000: return 32'h7FC00001; // NaN payload kept
      default:               return a ^ b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      a_cnt <= 0; b_cnt <= 0; z_cnt <= 0; z_busy <= 1'b0;
      mul_z_stb <= 1'b0; mul_z <= '0; m_a <= '0;
    end else begin
      if (mul_a_stb && mul_a_ack) begin
        a_cnt <= 0;
        m_a   <= mul_a;
      end else if (mul_a_stb) a_cnt <= a_cnt + 1;
      if (mul_b_stb && mul_b_ack) begin
        b_cnt <= 0;
        mul_z <= model_mul(m_a, mul_b);
        if (z_dly == 0) mul_z_stb <= 1'b1;
        else begin
          z_busy <= 1'b1;
          z_cnt  <= z_dly - 1;
        end
      end else if (mul_b_stb) b_cnt <= b_cnt + 1;
      if (z_busy) begin
        if (z_cnt == 0) begin
          mul_z_stb <= 1'b1;
          z_busy    <= 1'b0;
        end else z_cnt <= z_cnt - 1;
      end
      if (mul_z_stb && mul_z_ack) mul_z_stb <= 1'b0;
    end
  end

  // ---------------- per-cycle invariant monitor ----------------
  int   a_stb_cycles, b_stb_cycles, z_ack_cycles, rsp_cycles;
  logic prev_z_ack = 1'b0;

  always @(negedge clk) begin
    if (reset) prev_z_ack = 1'b0;
    else begin
      check("invariants",
            {26'b0, mul_a_stb && mul_b_stb, !$onehot0(req_ready), !$onehot0(rsp_valid),
             busy && (req_ready != '0), mul_z_ack && prev_z_ack, mul_z_ack && !mul_z_stb},
            32'h0);
      if (mul_a_stb) a_stb_cycles++;
      if (mul_b_stb) b_stb_cycles++;
      if (mul_z_ack) z_ack_cycles++;
      if (rsp_valid != '0) rsp_cycles++;
      prev_z_ack = mul_z_ack;
    end
  end

  // ---------------- helpers ----------------
  task automatic check_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_data"}, rsp_data, 32'h0);
    check({tag, "_mul_a"}, mul_a, 32'h0);
    check({tag, "_mul_b"}, mul_b, 32'h0);
    check({tag, "_ctl"}, {27'b0, mul_a_stb, mul_b_stb, mul_z_ack, busy, 1'b0}, 32'h0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
  endtask

  // Waits (bounded) for rsp_valid[idx], checks payload; returns at posedge+1
  // after the cycle in which the response was observed.
  task automatic wait_rsp(input int idx, input logic [31:0] exp, input string nm);
    bit seen = 1'b0;
    int c = 0;
    while (!seen && c < 100) begin
      @(negedge clk);
      if (rsp_valid[idx]) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    check({nm, "_seen"}, 32'(seen), 32'h1);
    if (seen) begin
      check({nm, "_data"}, rsp_data, exp);
      check({nm, "_grant"}, 32'(grant_id), 32'(idx));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Both requesters assert together: 0 must win when last_grant is 1.
  task automatic sim_pair(input string nm);
    ack_dly = 0; z_dly = 0;
    a_arr[0] = 32'h3FC00000; b_arr[0] = 32'hC0000000;
    a_arr[1] = 32'h40000000; b_arr[1] = 32'h40400000;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    @(negedge clk);
    check({nm, "_ready_first"}, 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = 2'b10;
    wait_rsp(0, 32'hC0400000, {nm, "_r0"});
    @(negedge clk);
    check({nm, "_ready_second"}, 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(1, 32'h40C00000, {nm, "_r1"});
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          idx;
    logic [31:0] a, b, z;
    int          ackd, zd, lat;
  } vec_t;

  vec_t vecs [5];

  task automatic run_one(input vec_t v, input int k);
    bit    got = 1'b0;
    bit    seen = 1'b0;
    int    n;
    string nm;
    nm = $sformatf("vec%0d", k);
    ack_dly = v.ackd; z_dly = v.zd;
    a_stb_cycles = 0; b_stb_cycles = 0; z_ack_cycles = 0;
    a_arr[v.idx] = v.a; b_arr[v.idx] = v.b;
    rsp_ready = '1;
    req_valid = '0;
    req_valid[v.idx] = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (req_ready[v.idx]) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check({nm, "_accept"}, 32'(got), 32'h1);
    if (got) begin
      // Scramble the requester inputs: the operation must use latched operands.
      n = 1;
      @(posedge clk); #1;
      req_valid = '0;
      a_arr[v.idx] = ~v.a; b_arr[v.idx] = ~v.b;
      while (!seen && n < 60) begin
        @(negedge clk);
        if (rsp_valid[v.idx]) seen = 1'b1;
        else begin
          @(posedge clk); #1;
          n++;
        end
      end
      check({nm, "_seen"}, 32'(seen), 32'h1);
      check({nm, "_latency"}, 32'(n), 32'(v.lat));
      check({nm, "_data"}, rsp_data, v.z);
      check({nm, "_grant"}, 32'(grant_id), 32'(v.idx));
      @(posedge clk); #1;
      @(negedge clk);
      check({nm, "_rsp_after"}, 32'(rsp_valid), 32'h0);
      check({nm, "_busy_after"}, 32'(busy), 32'h0);
      check({nm, "_a_stb_len"}, 32'(a_stb_cycles), 32'(v.ackd + 1));
      check({nm, "_b_stb_len"}, 32'(b_stb_cycles), 32'(v.ackd + 1));
      check({nm, "_z_ack_len"}, 32'(z_ack_cycles), 32'h1);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // latency = 4 + 2*ack_delay + compute delay
    vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 0, 0, 4};
    vecs[1] = '{1, 32'h3FC00000, 32'hC0000000, 32'hC0400000, 0, 0, 4};
    vecs[2] = '{1, 32'h7F800000, 32'h00000001, 32'h7F800000, 0, 2, 6};
    vecs[3] = '{0, 32'h7FC00001, 32'h40400000, 32'h7FC00001, 1, 0, 6};
    vecs[4] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 3, 5, 15};

    reset = 1'b1;
    req_valid = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0; b_arr[i] = '0;
    end

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst");
    @(posedge clk); #1 reset = 1'b0;

    // Single requests, fast and slow multiplier.
    for (int k = 0; k < 5; k++) run_one(vecs[k], k);

    // Simultaneous requests straight after reset.
    do_reset();
    sim_pair("pair");

    // Fairness: both held valid for six operations.
    ack_dly = 0; z_dly = 0;
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_rsp(k % 2, (k % 2 == 1) ? 32'h40C00000 : 32'hC0400000, $sformatf("fair%0d", k));
      if (k == 5) req_valid = 2'b00;
    end

    // Backpressure on requester 1 for ten cycles, requester 0 waiting.
    a_arr[1] = 32'h3FC00000; b_arr[1] = 32'hC0000000;
    a_arr[0] = 32'h40000000; b_arr[0] = 32'h40400000;
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    @(negedge clk);
    check("bp_ready1", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = 2'b01;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (rsp_valid[1]) seen = 1'b1;
        else begin
          @(posedge clk); #1;
        end
      end
      check("bp_seen", 32'(seen), 32'h1);
    end
    for (int j = 0; j < 10; j++) begin
      if (j > 0) @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'h2);
      check("bp_hold_data", rsp_data, 32'hC0400000);
      check("bp_hold_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_release_valid", 32'(rsp_valid), 32'h2);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_done_valid", 32'(rsp_valid), 32'h0);
    check("bp_next_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(0, 32'h40C00000, "bp_r0");

    // Reset while waiting for Z on behalf of requester 1.
    ack_dly = 0; z_dly = 20;
    a_arr[1] = 32'h40000000; b_arr[1] = 32'h40400000;
    req_valid = 2'b10;
    @(negedge clk);
    check("abort_ready", 32'(req_ready), 32'h2);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_in_wait_z", {29'b0, busy, mul_a_stb, mul_b_stb}, 32'h4);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero("abort");
    @(posedge clk); #1 reset = 1'b0;
    rsp_cycles = 0;
    repeat (30) @(posedge clk);
    #1;
    check("abort_no_rsp", 32'(rsp_cycles), 32'h0);
    sim_pair("post_abort");

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
